router_reg: RTL
===============

# router_reg

Datapath register stage of the 1x3 router, sitting directly downstream of the router FSM and upstream of the three output FIFOs. It consumes the FSM's state decodes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) together with the raw input byte stream. It produces the byte written into the selected FIFO (dout) and the packet status flags the FSM consumes: parity_done and low_packet_valid. It also holds the header byte and the byte that arrives while the FIFO is full, and checks the packet's parity byte.

## Interface
- WIDTH, 8, data byte width; header bits [1:0] carry the destination address.
- clk  in  1  rising-edge clock; all state updates on this edge.
- reset  in  1  synchronous, active-high reset.
- packet_valid  in  1  source asserts while header/payload bytes are on datain; deasserted on the parity byte.
- datain  in  WIDTH  input byte stream.
- fifo_full  in  1  selected FIFO full.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  in  1 each  one-hot FSM state decodes.
- dout  out  WIDTH  byte to the selected FIFO.
- parity_done  out  1  parity byte of the current packet has been captured.
- low_packet_valid  out  1  packet_valid fell while in ld_state.
- err  out  1  parity mismatch for the current packet.

## Operation
- Internal registers: header_byte, full_byte, internal_parity, packet_parity, and parity_done_q (a one-cycle delayed copy of parity_done).
- **Header capture**
  - Condition: detect_add && packet_valid && datain[1:0] != 2'b11.
  - Action: header_byte <= datain.
  - Address 3 is ignored.
- **dout, priority order**
  - lfd_state: dout <= header_byte.
  - ld_state && !fifo_full: dout <= datain.
  - ld_state && fifo_full: full_byte <= datain; dout holds.
  - laf_state: dout <= full_byte.
  - Otherwise dout holds.
- **low_packet_valid**
  - Cleared by rst_int_reg.
  - Otherwise set by ld_state && !packet_valid.
  - Otherwise holds.
- **parity_done**
  - Cleared by detect_add.
  - Set by (ld_state && !fifo_full && !packet_valid).
  - Also set by (laf_state && low_packet_valid && !parity_done).
  - Otherwise holds.
- **internal_parity**
  - Cleared by detect_add.
  - lfd_state: ^= header_byte.
  - ld_state && packet_valid: ^= datain. Every payload byte is accumulated exactly once, whether it goes to dout or to full_byte.
- **packet_parity**
  - Loaded with datain on ld_state && !packet_valid && !low_packet_valid, i.e. the first parity-byte cycle.
  - Cleared by detect_add.
- **err**
  - Cleared by detect_add.
  - On parity_done && !parity_done_q: err <= (internal_parity != packet_parity) (gated by the macro in Configuration).
  - Sticky until the next detect_add.
- **Reset mid-packet:** all registers return to reset values; no partial state survives.

## Timing
- Reset values: dout=0, parity_done=0, low_packet_valid=0, err=0, header_byte=0, full_byte=0, internal_parity=0, packet_parity=0, parity_done_q=0.
- dout latency: one cycle.
  - Byte on datain in ld_state appears on dout the following cycle.
  - Header appears on dout one cycle after lfd_state is sampled.
- parity_done and low_packet_valid rise one cycle after the qualifying condition is sampled.
- err is valid two cycles after the parity byte is sampled on the direct path (parity_done edge, then compare).
- FIFO full during the last payload byte:
  - The byte is held in full_byte.
  - It is emitted in laf_state.
  - Its parity is counted once, at capture.
- detect_add while parity_done=1 clears parity_done, internal_parity, packet_parity and err on the same edge.

## Configuration
- ROUTER_REG_PARITY_CHECK_EN defined:
  - internal_parity, packet_parity and the err compare are compiled in.
  - err behaves as in Operation.
- ROUTER_REG_PARITY_CHECK_EN undefined:
  - The parity registers and comparator are removed.
  - err is tied to 0.
  - dout, parity_done and low_packet_valid behaviour is unchanged.

## Test plan
- **Reset:** assert reset 2 cycles with datain=8'hFF and all decodes high -> all outputs 0 on the cycle after reset is sampled.
- **Good packet:**
  - Stimulus: header 8'h0D (addr 1), payload 8'hAA, 8'h55, parity 8'hF2, no full.
  - Required: dout sequence 8'h0D, 8'hAA, 8'h55; parity_done=1; low_packet_valid=1; err=0.
- **Bad parity:** same packet with parity byte 8'h00 -> err=1, held until the next detect_add, then 0.
- **FIFO full:**
  - Stimulus: fifo_full=1 while 8'h55 is presented in ld_state.
  - Required: dout holds 8'hAA; 8'h55 is emitted in laf_state; err=0 with parity 8'hF2.
- **Address 3:** detect_add && packet_valid with datain=8'h03 -> header_byte unchanged.
- **Macro off:** bad-parity scenario rebuilt without ROUTER_REG_PARITY_CHECK_EN -> err stays 0; dout and parity_done identical to the macro-on run.

Source files
------------

// File: rtl/router_reg_if.sv
// router_reg_if
//
// Bundles the router_reg datapath interface: the raw byte stream from the
// source, the FIFO-full flag, the one-hot FSM state decodes, and the byte and
// status flags produced back towards the FIFO and the FSM.
//
//   WIDTH             data byte width (header bits [1:0] are the address)
//   packet_valid      source has header/payload on datain (low on parity byte)
//   datain            input byte stream
//   fifo_full         selected output FIFO is full
//   detect_add .. rst_int_reg   one-hot FSM state decodes
//   dout              byte to the selected FIFO
//   parity_done       parity byte of the current packet has been captured
//   low_packet_valid  packet_valid fell while in ld_state
//   err               parity mismatch for the current packet
//
// Modports:
//   master  - the side that drives the stream/decodes and observes the flags
//   slave   - router_reg itself
interface router_reg_if #(
  parameter int WIDTH = 8
);

  logic             packet_valid;
  logic [WIDTH-1:0] datain;
  logic             fifo_full;
  logic             detect_add;
  logic             lfd_state;
  logic             ld_state;
  logic             laf_state;
  logic             full_state;
  logic             rst_int_reg;
  logic [WIDTH-1:0] dout;
  logic             parity_done;
  logic             low_packet_valid;
  logic             err;

  modport master (
    output packet_valid, datain, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err
  );

  modport slave (
    input  packet_valid, datain, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err
  );

endinterface

// File: rtl/router_reg.sv
// router_reg
//
// Datapath register stage of the 1x3 router. Sits between the router FSM and
// the three output FIFOs: it latches the header byte, forwards payload bytes to
// the selected FIFO one cycle after they are sampled, parks the byte that
// arrives while the FIFO is full and replays it in laf_state, and produces the
// packet status flags parity_done / low_packet_valid used by the FSM.
//
// Optional parity checking is compiled in when ROUTER_REG_PARITY_CHECK_EN is
// defined: the running XOR of header and payload is compared against the
// packet's parity byte and a sticky err flag is raised on mismatch. With the
// macro undefined the parity registers are absent and err is tied low.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    router_reg_if.slave (stream, fifo_full, FSM decodes, dout, flags)
module router_reg #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  router_reg_if.slave bus
);

  logic [WIDTH-1:0] header_byte;
  logic [WIDTH-1:0] full_byte;
  logic [WIDTH-1:0] dout_q;
  logic             parity_done_q;
  logic             low_pkt_valid_q;

  // full_state needs no datapath action: every register simply holds while the
  // FSM waits for the FIFO to drain, which is the default branch below.
  logic unused_full_state;
  assign unused_full_state = bus.full_state;

  // ---------------------------------------------------------------------------
  // Header capture. Address 3 is not a valid destination, so such a header
  // leaves the previously latched header untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      header_byte <= '0;
    end else if (bus.detect_add && bus.packet_valid && (bus.datain[1:0] != 2'b11)) begin
      header_byte <= bus.datain;
    end
  end

  // ---------------------------------------------------------------------------
  // Output byte and full-byte holding register.
  // A byte sampled in ld_state while the FIFO is full cannot be written, so it
  // is parked in full_byte and dout keeps its last value; laf_state replays it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q    <= '0;
      full_byte <= '0;
    end else if (bus.lfd_state) begin
      dout_q <= header_byte;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_q <= bus.datain;
    end else if (bus.ld_state && bus.fifo_full) begin
      full_byte <= bus.datain;
    end else if (bus.laf_state) begin
      dout_q <= full_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // low_packet_valid: source dropped packet_valid while bytes were being
  // loaded, i.e. the parity byte has been presented.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      low_pkt_valid_q <= 1'b0;
    end else if (bus.rst_int_reg) begin
      low_pkt_valid_q <= 1'b0;
    end else if (bus.ld_state && !bus.packet_valid) begin
      low_pkt_valid_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // parity_done: set when the parity byte is written straight through, or,
  // if the parity byte was parked in full_byte, when laf_state replays it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_done_q <= 1'b0;
    end else if (bus.detect_add) begin
      parity_done_q <= 1'b0;
    end else if ((bus.ld_state && !bus.fifo_full && !bus.packet_valid) ||
                 (bus.laf_state && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_q <= 1'b1;
    end
  end

  assign bus.dout             = dout_q;
  assign bus.parity_done      = parity_done_q;
  assign bus.low_packet_valid = low_pkt_valid_q;

`ifdef ROUTER_REG_PARITY_CHECK_EN
  logic [WIDTH-1:0] internal_parity;
  logic [WIDTH-1:0] packet_parity;
  logic             parity_done_d1;
  logic             err_q;

  // Running XOR of header and payload. A payload byte is counted in the cycle
  // it is sampled in ld_state, whether it goes to dout or into full_byte, so
  // the laf_state replay must not count it again.
  always_ff @(posedge clk) begin
    if (reset) begin
      internal_parity <= '0;
    end else if (bus.detect_add) begin
      internal_parity <= '0;
    end else if (bus.lfd_state) begin
      internal_parity <= internal_parity ^ header_byte;
    end else if (bus.ld_state && bus.packet_valid) begin
      internal_parity <= internal_parity ^ bus.datain;
    end
  end

  // Only the first parity-byte cycle is captured; low_packet_valid is already
  // high on any later ld_state cycle of the same packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      packet_parity <= '0;
    end else if (bus.detect_add) begin
      packet_parity <= '0;
    end else if (bus.ld_state && !bus.packet_valid && !low_pkt_valid_q) begin
      packet_parity <= bus.datain;
    end
  end

  // Compare once, on the rising edge of parity_done; err is sticky until the
  // next packet header is detected.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_done_d1 <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      parity_done_d1 <= parity_done_q;
      if (bus.detect_add) begin
        err_q <= 1'b0;
      end else if (parity_done_q && !parity_done_d1) begin
        err_q <= (internal_parity != packet_parity);
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
